event_counter_ctrl: RTL and testbench
=====================================

Name: event_counter_ctrl

Overview:
- Controller that sequences the front-panel event counter datapath.
- Debounces the raw KEY buttons and arbitrates between clear, hold and count requests.
- Runs a 4-state mode FSM and issues single-cycle increment and clear strobes to the external counter register.
- Sits between the board pins (KEY, SW-derived qualifier) and the counter and HEX-decoder datapath; replaces the ad-hoc edge-detect logic.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz). Minimum 2.
- CNT_W, 10, width of the counter value fed back from the datapath.
- LIMIT, 1023, saturation value. When cnt_value equals LIMIT, further increments are refused.

Ports:
- CLOCK_50 in 1: single clock for the whole block.
- reset in 1: synchronous reset, active-high.
- key_count_n in 1: raw count button (KEY[0]), active-low, asynchronous.
- key_clear_n in 1: raw clear button (KEY[1]), active-low, asynchronous.
- key_hold_n in 1: raw hold/resume button (KEY[2]), active-low, asynchronous.
- event_ok in 1: event qualifier from switch decode, asynchronous level.
- cnt_value in CNT_W: current counter value from the datapath.
- cnt_inc out 1: one-cycle increment strobe, registered.
- cnt_clr out 1: one-cycle clear strobe, registered.
- state out 2: current mode, encoded IDLE=00, RUN=01, HOLD=10, SAT=11.
- saturated out 1: high while in SAT, or while in HOLD entered from SAT.

Behaviour:
- Input synchronisation:
  - Every key and event_ok passes through a 2-FF synchroniser. The key synchronisers reset to 1; the event_ok synchroniser resets to 0.
- Debounce (per key):
  - The debounced level resets to 1 (released).
  - A counter runs while the synchronised input differs from the debounced level. It restarts at 0 on any agreement.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the input still differs, the debounced level flips on the next edge.
  - A press pulse is emitted for exactly one cycle, the cycle after the debounced level goes 1->0.
- Arming:
  - After reset, each key must be seen debounced-released once before it can produce a press.
  - A key held through reset release therefore generates no press.
- Arbitration:
  - Press pulses arriving in the same cycle resolve as clear > hold > count.
  - Only the winning request is acted on; losing requests are dropped, not queued.
- Latency:
  - Required: cnt_inc/cnt_clr are asserted exactly DEBOUNCE_CYCLES+3 cycles after a clean raw falling edge that is held stable.
- event_ok sampling:
  - event_ok is sampled, synchronised, in the same cycle as the count press pulse.
- FSM transitions:
  - IDLE, count & event_ok: pulse cnt_inc, go to RUN.
  - IDLE, count & !event_ok: no strobe, stay in IDLE.
  - RUN, count & event_ok & cnt_value!=LIMIT: pulse cnt_inc.
  - RUN, count & event_ok & cnt_value==LIMIT: no strobe, go to SAT.
  - RUN, count & !event_ok: ignored.
  - IDLE/RUN/SAT, hold: store the current state in resume_state, go to HOLD.
  - HOLD, hold: return to resume_state.
  - HOLD, count: ignored.
  - SAT, count: ignored.
  - Any state, clear: pulse cnt_clr, go to IDLE, set resume_state=IDLE.
- Reset values:
  - state=IDLE, resume_state=IDLE, cnt_inc=0, cnt_clr=0, saturated=0.
  - All debounce counters are 0 and all arm bits are 0.
- Reset mid-operation:
  - A reset asserted during a debounce window, or in the cycle a strobe would issue, discards the pending event. No strobe appears after reset release.
- Strobe exclusivity:
  - cnt_inc and cnt_clr are never high in the same cycle.
  - Neither strobe is ever high for 2 consecutive cycles.
- Counter comparison:
  - cnt_value is compared unsigned at the full CNT_W width.
  - The controller never causes a wrap; saturation is enforced here.

Decomposition:
- Shared package event_counter_pkg holds:
  - the state encoding constants (IDLE, RUN, HOLD, SAT);
  - the default DEBOUNCE_CYCLES;
  - the key index constants (KEY_COUNT=0, KEY_CLEAR=1, KEY_HOLD=2).
- One sub-module, key_debounce:
  - contains the sync, debounce counter, arm bit and press pulse;
  - is instantiated 3 times.
- The FSM and arbitration live in the top-level module.

Test Plan (sim with DEBOUNCE_CYCLES=4, LIMIT=3):
1. Reset, event_ok=1, one clean count press -> cnt_inc high for 1 cycle, exactly 7 cycles after the raw edge; state 00->01.
2. Count press with event_ok=0 in IDLE -> no cnt_inc; state stays 00. Raw glitch low for 3 cycles -> no press at all.
3. In RUN, cnt_value=3, count press -> no cnt_inc, state=11, saturated=1. A further count press -> no strobe.
4. In RUN, hold press then count press -> state=10, no cnt_inc. Second hold press -> state=01.
5. Clear and count raw edges in the same cycle -> only cnt_clr pulses; state=00.
6. Key held low across a reset pulse, then reset released -> no strobe until the key is released and pressed again. Then cnt_inc appears after 7 cycles.

Source files
------------

// File: rtl/event_counter_pkg.sv
// event_counter_pkg: shared mode encoding, key indices and debounce default
package event_counter_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] HOLD = 2'b10;
    localparam logic [1:0] SAT  = 2'b11;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;

    localparam int KEY_COUNT = 0;
    localparam int KEY_CLEAR = 1;
    localparam int KEY_HOLD  = 2;
    localparam int NUM_KEYS  = 3;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronise, debounce and arm one active-low key, emitting a one-cycle press pulse
module key_debounce
    import event_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 2);

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_level_d;
    logic          r_arm;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_acnt;
    logic          w_in;
    logic          w_differ;
    logic          w_released;
    logic          w_flip;

    assign w_in       = r_sync[1];
    assign w_differ   = w_in != r_level;
    assign w_released = r_level & w_in;
    assign w_flip     = w_differ && r_cnt == CW'(DEBOUNCE_CYCLES - 1);

    // Arming needs more agreeing cycles than the synchroniser reset values can fake
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= 2'b11;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_arm     <= 1'b0;
            r_cnt     <= '0;
            r_acnt    <= '0;
        end else begin
            r_sync    <= {r_sync[0], i_key_n};
            r_level_d <= r_level;
            r_cnt     <= (w_differ && !w_flip) ? r_cnt + CW'(1) : '0;
            r_level   <= w_flip ? ~r_level : r_level;
            r_acnt    <= (w_released && !r_arm) ? r_acnt + CW'(1) : '0;
            r_arm     <= r_arm | (w_released && r_acnt == CW'(DEBOUNCE_CYCLES));
        end
    end

    assign o_press = r_arm & r_level_d & ~r_level;

endmodule

// File: rtl/event_counter_ctrl.sv
// event_counter_ctrl: debounced key arbitration and mode FSM driving counter increment/clear strobes
module event_counter_ctrl
    import event_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 10,
    parameter int LIMIT           = 1023
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             key_count_n,
    input  logic             key_clear_n,
    input  logic             key_hold_n,
    input  logic             event_ok,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             cnt_inc,
    output logic             cnt_clr,
    output logic [1:0]       state,
    output logic             saturated
);

    logic [NUM_KEYS-1:0] w_keys_n;
    logic [NUM_KEYS-1:0] w_press;
    logic [1:0]          r_ok_sync;
    logic [1:0]          r_state;
    logic [1:0]          r_resume;
    logic [1:0]          w_next;
    logic [1:0]          w_resume_next;
    logic                r_inc;
    logic                r_clr;
    logic                w_inc;
    logic                w_clr;
    logic                w_do_hold;
    logic                w_do_cnt;
    logic                w_full;

    assign w_keys_n[KEY_COUNT] = key_count_n;
    assign w_keys_n[KEY_CLEAR] = key_clear_n;
    assign w_keys_n[KEY_HOLD]  = key_hold_n;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .i_clk   (CLOCK_50),
            .i_rst   (reset),
            .i_key_n (w_keys_n[k]),
            .o_press (w_press[k])
        );
    end

    // Clear beats hold beats count; losers are simply dropped
    assign w_clr     = w_press[KEY_CLEAR];
    assign w_do_hold = w_press[KEY_HOLD] & ~w_clr;
    assign w_do_cnt  = w_press[KEY_COUNT] & ~w_clr & ~w_press[KEY_HOLD] & r_ok_sync[1];
    assign w_full    = r_state == RUN && cnt_value == CNT_W'(LIMIT);

    always_comb begin
        w_next        = r_state;
        w_resume_next = r_resume;
        w_inc         = 1'b0;
        if (w_clr) begin
            w_next        = IDLE;
            w_resume_next = IDLE;
        end else if (w_do_hold) begin
            w_next        = (r_state == HOLD) ? r_resume : HOLD;
            w_resume_next = (r_state == HOLD) ? r_resume : r_state;
        end else if (w_do_cnt && (r_state == IDLE || r_state == RUN)) begin
            w_inc  = !w_full;
            w_next = w_full ? SAT : RUN;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state   <= IDLE;
            r_resume  <= IDLE;
            r_inc     <= 1'b0;
            r_clr     <= 1'b0;
            r_ok_sync <= 2'b00;
        end else begin
            r_state   <= w_next;
            r_resume  <= w_resume_next;
            r_inc     <= w_inc;
            r_clr     <= w_clr;
            r_ok_sync <= {r_ok_sync[0], event_ok};
        end
    end

    assign cnt_inc   = r_inc;
    assign cnt_clr   = r_clr;
    assign state     = r_state;
    assign saturated = r_state == SAT || (r_state == HOLD && r_resume == SAT);

endmodule

// File: tb/tb_event_counter_ctrl.sv
// tb_event_counter_ctrl: directed scoreboard bench for the event counter controller
module tb_event_counter_ctrl;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       kc;
    logic       kl;
    logic       kh;
    logic       ok;
    logic [9:0] cv;
    logic       inc;
    logic       clr;
    logic [1:0] st;
    logic       sat;
    logic       prev_inc = 1'b0;
    logic       prev_clr = 1'b0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_err = 0;
    exp_t       q[$];

    event_counter_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(10), .LIMIT(3)) dut (
        .CLOCK_50    (clk),
        .reset       (rst),
        .key_count_n (kc),
        .key_clear_n (kl),
        .key_hold_n  (kh),
        .event_ok    (ok),
        .cnt_value   (cv),
        .cnt_inc     (inc),
        .cnt_clr     (clr),
        .state       (st),
        .saturated   (sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_key(input int k, input logic v);
        if (k == 0) kc = v;
        else if (k == 1) kl = v;
        else kh = v;
    endtask

    // kind: 0 none, 1 increment, 2 clear; strobe due 7 cycles after the raw edge
    task automatic press(input int k, input int kind, input int exp_st);
        if (kind != 0) q.push_back('{kind, cyc + 7});
        set_key(k, 1'b0);
        tick(12);
        set_key(k, 1'b1);
        tick(12);
        chk("pending", q.size(), 0);
        chk("state", int'(st), exp_st);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (inc || clr) begin
            chk("excl", int'(inc & clr), 0);
            chk("consec", int'((prev_inc & inc) | (prev_clr & clr)), 0);
            if (q.size() == 0) chk("unexpected", int'({clr, inc}), 0);
            else begin
                e = q.pop_front();
                chk("kind", int'({clr, inc}), e.kind);
                chk("cycle", cyc, e.cyc);
            end
        end
        prev_inc = inc;
        prev_clr = clr;
    end

    initial begin
        rst = 1'b1;
        kc  = 1'b1;
        kl  = 1'b1;
        kh  = 1'b1;
        ok  = 1'b1;
        cv  = '0;
        tick(3);
        chk("rst_state", int'(st), 0);
        chk("rst_inc", int'(inc), 0);
        chk("rst_clr", int'(clr), 0);
        chk("rst_sat", int'(sat), 0);
        rst = 1'b0;
        tick(10);
        press(0, 1, 1);
        press(1, 2, 0);
        ok = 1'b0;
        tick(4);
        press(0, 0, 0);
        kc = 1'b0;
        tick(3);
        kc = 1'b1;
        tick(12);
        chk("glitch_state", int'(st), 0);
        ok = 1'b1;
        tick(4);
        press(0, 1, 1);
        cv = 10'd3;
        press(0, 0, 3);
        chk("sat_on", int'(sat), 1);
        press(0, 0, 3);
        press(1, 2, 0);
        chk("sat_clr", int'(sat), 0);
        cv = 10'd0;
        press(0, 1, 1);
        press(2, 0, 2);
        chk("hold_sat", int'(sat), 0);
        press(0, 0, 2);
        press(2, 0, 1);
        cv = 10'd3;
        press(0, 0, 3);
        press(2, 0, 2);
        chk("hold_from_sat", int'(sat), 1);
        press(2, 0, 3);
        q.push_back('{2, cyc + 7});
        kc = 1'b0;
        kl = 1'b0;
        tick(12);
        kc = 1'b1;
        kl = 1'b1;
        tick(12);
        chk("pending", q.size(), 0);
        chk("arb_state", int'(st), 0);
        cv = 10'd0;
        kc = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(20);
        chk("held_state", int'(st), 0);
        kc = 1'b1;
        tick(20);
        press(0, 1, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
